// File: rtl/frag_reader.sv
// rtl/frag_reader.sv - streams packed fragments from main memory onto a valid/ready word stream
// Optional stall counter built when FRAG_READER_PERF_EN is defined.
module frag_reader #(
    parameter int DATA_WIDTH                  = 32,
    parameter int MAIN_MEM_ADDR_WIDTH         = 32,
    parameter int LOCAL_VERTEX_MEM_ADDR_WIDTH = 4,
    parameter int RD_LATENCY                  = 0,
    parameter int BUF_DEPTH                   = 4
) (
    input  logic                                   clk,
    input  logic                                   resetn,
    input  logic                                   en,
    input  logic                                   start,
    output logic                                   done,
    output logic                                   ready,
    input  logic [MAIN_MEM_ADDR_WIDTH-1:0]         f_array_ptr,
    input  logic [LOCAL_VERTEX_MEM_ADDR_WIDTH-1:0] vertexSize,
    input  logic [15:0]                            num_frags,
    output logic                                   mem_rd_en,
    output logic [MAIN_MEM_ADDR_WIDTH-1:0]         mem_rd_addr,
    input  logic [DATA_WIDTH-1:0]                  mem_rd_data,
    output logic [DATA_WIDTH-1:0]                  out_data,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic                                   out_sop,
    output logic                                   out_eop,
    output logic [31:0]                            stall_cycles
);
    localparam int PW = $clog2(BUF_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

    state_t                                 state;
    logic [MAIN_MEM_ADDR_WIDTH-1:0]         rd_addr;
    logic [31:0]                            total;
    logic [31:0]                            issued;
    logic [31:0]                            popped;
    logic [LOCAL_VERTEX_MEM_ADDR_WIDTH-1:0] vsize;
    logic [LOCAL_VERTEX_MEM_ADDR_WIDTH-1:0] word_idx;
    logic [RD_LATENCY:0]                    rd_sr;
    logic [DATA_WIDTH-1:0]                  buffer [BUF_DEPTH];
    logic [PW-1:0]                          wr_ptr;
    logic [PW-1:0]                          rd_ptr;
    logic [PW:0]                            count;
    logic [PW:0]                            inflight;
    logic                                   issue;
    logic                                   wr;
    logic                                   pop;

    always_comb begin
        inflight = '0;
        for (int i = 0; i <= RD_LATENCY; i++) begin
            inflight = inflight + (PW+1)'(rd_sr[i]);
        end
    end

    // Credit check: never request more than the buffer can absorb once everything lands.
    assign issue = (state == S_RUN) && en && (issued < total)
                   && ((count + inflight) < (PW+1)'(BUF_DEPTH));
    assign wr    = rd_sr[RD_LATENCY];
    assign pop   = out_valid && out_ready;

    assign mem_rd_en   = issue;
    assign mem_rd_addr = rd_addr;
    assign out_valid   = (count != '0);
    assign out_data    = out_valid ? buffer[rd_ptr] : '0;
    assign out_sop     = out_valid && (word_idx == '0);
    assign out_eop     = out_valid && (word_idx == vsize);

    always_ff @(posedge clk) begin
        if (wr) begin
            buffer[wr_ptr] <= mem_rd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= S_IDLE;
            done     <= 1'b0;
            ready    <= 1'b1;
            rd_addr  <= '0;
            total    <= '0;
            issued   <= '0;
            popped   <= '0;
            vsize    <= '0;
            word_idx <= '0;
            rd_sr    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            done  <= 1'b0;
            rd_sr <= (rd_sr << 1) | (RD_LATENCY+1)'(issue);
            count <= count + (PW+1)'(wr) - (PW+1)'(pop);
            if (wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                popped   <= popped + 32'd1;
                word_idx <= (word_idx == vsize) ? '0 : word_idx + 1'b1;
            end
            if (issue) begin
                rd_addr <= rd_addr + 1'b1;
                issued  <= issued + 32'd1;
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        vsize    <= vertexSize;
                        total    <= 32'(num_frags) * (32'(vertexSize) + 32'd1);
                        rd_addr  <= f_array_ptr;
                        issued   <= '0;
                        popped   <= '0;
                        word_idx <= '0;
                        ready    <= 1'b0;
                        state    <= (num_frags == 16'd0) ? S_FIN : S_RUN;
                    end
                end
                S_RUN: begin
                    if (pop && (popped == total - 32'd1)) begin
                        done  <= 1'b1;
                        ready <= 1'b1;
                        state <= S_FIN;
                    end
                end
                S_FIN: begin
                    // Arriving from RUN the pulse is already out; from IDLE (empty job) emit it now.
                    if (!done) begin
                        done  <= 1'b1;
                        ready <= 1'b1;
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef FRAG_READER_PERF_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            stall_q <= '0;
        end else if ((state == S_IDLE) && start) begin
            stall_q <= '0;
        end else if ((state == S_RUN) && out_valid && !out_ready && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_frag_reader.sv
// tb/tb_frag_reader.sv - checks frag_reader (latency 0 and latency 2 instances) against a fragment-layout model
module tb_frag_reader;
`ifdef FRAG_READER_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        en = 1'b1;
    logic        start = 1'b0;
    logic [31:0] f_array_ptr = '0;
    logic [3:0]  vertexSize = '0;
    logic [15:0] num_frags = '0;
    logic        out_ready = 1'b1;

    logic        done [2];
    logic        ready [2];
    logic        rd_en [2];
    logic [31:0] rd_addr [2];
    logic [31:0] rd_data [2];
    logic [31:0] out_data [2];
    logic        out_valid [2];
    logic        out_sop [2];
    logic        out_eop [2];
    logic [31:0] stall [2];

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    logic [31:0] salt = 32'h1234_5678;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    frag_reader u0 (
        .clk(clk), .resetn(resetn), .en(en), .start(start), .done(done[0]), .ready(ready[0]),
        .f_array_ptr(f_array_ptr), .vertexSize(vertexSize), .num_frags(num_frags),
        .mem_rd_en(rd_en[0]), .mem_rd_addr(rd_addr[0]), .mem_rd_data(rd_data[0]),
        .out_data(out_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready),
        .out_sop(out_sop[0]), .out_eop(out_eop[0]), .stall_cycles(stall[0])
    );

    frag_reader #(.RD_LATENCY(2), .BUF_DEPTH(DEPTH)) u2 (
        .clk(clk), .resetn(resetn), .en(en), .start(start), .done(done[1]), .ready(ready[1]),
        .f_array_ptr(f_array_ptr), .vertexSize(vertexSize), .num_frags(num_frags),
        .mem_rd_en(rd_en[1]), .mem_rd_addr(rd_addr[1]), .mem_rd_data(rd_data[1]),
        .out_data(out_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready),
        .out_sop(out_sop[1]), .out_eop(out_eop[1]), .stall_cycles(stall[1])
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ salt;
    endfunction

    // Fixed-latency memories: 1 cycle and 3 cycles from request to data.
    logic [31:0] m0, m2a, m2b, m2c;
    always @(posedge clk) begin
        m0  <= rd_en[0] ? mem_word(rd_addr[0]) : 32'hDEAD_BEEF;
        m2a <= rd_en[1] ? mem_word(rd_addr[1]) : 32'hDEAD_BEEF;
        m2b <= m2a;
        m2c <= m2b;
    end
    assign rd_data[0] = m0;
    assign rd_data[1] = m2c;

    logic [33:0] got_q [2][$];
    logic [31:0] adr_q [2][$];
    int outstanding [2], max_out [2], en_viol [2], stab_viol [2], stall_obs [2];
    int done_cnt [2], done_cyc [2], first_issue [2], last_issue [2];
    bit hold_pend [2];
    logic [33:0] held [2];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rd_en[i]) begin
                adr_q[i].push_back(rd_addr[i]);
                outstanding[i]++;
                if (!en) en_viol[i]++;
                if (first_issue[i] < 0) first_issue[i] = cyc;
                last_issue[i] = cyc;
            end
            if (out_valid[i] && out_ready) begin
                got_q[i].push_back({out_sop[i], out_eop[i], out_data[i]});
                outstanding[i]--;
            end
            if (outstanding[i] > max_out[i]) max_out[i] = outstanding[i];
            if (out_valid[i] && !out_ready) stall_obs[i]++;
            if (hold_pend[i] && (!out_valid[i] || {out_sop[i], out_eop[i], out_data[i]} !== held[i]))
                stab_viol[i]++;
            hold_pend[i] = out_valid[i] && !out_ready;
            held[i] = {out_sop[i], out_eop[i], out_data[i]};
            if (done[i]) begin
                done_cnt[i]++;
                done_cyc[i] = cyc;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic clear_mon();
        for (int i = 0; i < 2; i++) begin
            got_q[i].delete();
            adr_q[i].delete();
            outstanding[i] = 0; max_out[i] = 0; en_viol[i] = 0; stab_viol[i] = 0;
            stall_obs[i] = 0; done_cnt[i] = 0; done_cyc[i] = -1;
            first_issue[i] = -1; last_issue[i] = -1; hold_pend[i] = 1'b0;
        end
    endtask

    // Index of the first stream word that disagrees with the fragment layout, -1 if none.
    function automatic int first_bad_word(input int j, input logic [31:0] p, input int vs, input int total);
        for (int i = 0; i < total; i++) begin
            logic [33:0] exp;
            exp = {(i % (vs + 1)) == 0, (i % (vs + 1)) == vs, mem_word(p + 32'(i))};
            if (i >= got_q[j].size() || got_q[j][i] !== exp) return i;
        end
        return (got_q[j].size() == total) ? -1 : total;
    endfunction

    function automatic int first_bad_addr(input int j, input logic [31:0] p, input int total);
        for (int i = 0; i < total; i++) begin
            if (i >= adr_q[j].size() || adr_q[j][i] !== p + 32'(i)) return i;
        end
        return (adr_q[j].size() == total) ? -1 : total;
    endfunction

    // mode: 0 free-running, 1 out_ready low for 5 cycles, 2 en low for 3 cycles, 3 random en/out_ready
    task automatic run_xfer(input string tag, input logic [31:0] p, input logic [3:0] vs,
                            input logic [15:0] nf, input int mode);
        int total, t0, k;
        total = int'(nf) * (int'(vs) + 1);
        clear_mon();
        salt = $urandom;
        @(posedge clk); #1;
        start = 1'b1; f_array_ptr = p; vertexSize = vs; num_frags = nf;
        t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0; f_array_ptr = $urandom; vertexSize = 4'($urandom); num_frags = 16'($urandom);
        chk({tag, "_ready_low"}, ready[0], 1'b0);
        for (int b = 0; b < 3000; b++) begin
            if (done_cnt[0] > 0 && done_cnt[1] > 0) break;
            k = cyc - t0;
            case (mode)
                1: out_ready = !(k >= 5 && k <= 9);
                2: en = !(k >= 2 && k <= 4);
                3: begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    en = ($urandom_range(0, 3) != 0);
                end
                default: ;
            endcase
            @(posedge clk); #1;
        end
        out_ready = 1'b1; en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int j = 0; j < 2; j++) begin
            chk({tag, "_done_once"}, 64'(done_cnt[j]), 64'd1);
            chk({tag, "_words"}, 64'(first_bad_word(j, p, int'(vs), total)), -64'sd1);
            chk({tag, "_addrs"}, 64'(first_bad_addr(j, p, total)), -64'sd1);
            chk({tag, "_credit"}, 64'(max_out[j] <= DEPTH), 64'd1);
            chk({tag, "_en_gate"}, 64'(en_viol[j]), 64'd0);
            chk({tag, "_stable"}, 64'(stab_viol[j]), 64'd0);
            chk({tag, "_stall"}, stall[j], PERF ? 64'(stall_obs[j]) : 64'd0);
            chk({tag, "_ready_back"}, ready[j], 1'b1);
        end
        if (mode == 0) begin
            if (nf == 0) begin
                chk({tag, "_zero_done_cyc"}, 64'(done_cyc[0]), 64'(t0 + 2));
            end else begin
                chk({tag, "_first_issue"}, 64'(first_issue[0]), 64'(t0 + 1));
                chk({tag, "_last_issue"}, 64'(last_issue[0]), 64'(t0 + total));
                chk({tag, "_done_cyc"}, 64'(done_cyc[0]), 64'(t0 + 3 + total));
            end
        end
        if (mode == 1) begin
            chk({tag, "_stall5_l0"}, stall[0], PERF ? 64'd5 : 64'd0);
            chk({tag, "_stall5_l2"}, stall[1], PERF ? 64'd5 : 64'd0);
        end
    endtask

    initial begin
        clear_mon();
        repeat (3) @(posedge clk);
        #1;
        for (int j = 0; j < 2; j++) begin
            chk("rst_ready", ready[j], 1'b1);
            chk("rst_done", done[j], 1'b0);
            chk("rst_rd_en", rd_en[j], 1'b0);
            chk("rst_rd_addr", rd_addr[j], 32'd0);
            chk("rst_valid", out_valid[j], 1'b0);
            chk("rst_data", out_data[j], 32'd0);
            chk("rst_sop_eop", {out_sop[j], out_eop[j]}, 2'b00);
            chk("rst_stall", stall[j], 32'd0);
        end
        resetn = 1'b1;
        repeat (2) @(posedge clk);

        run_xfer("basic", 32'h100, 4'd3, 16'd2, 0);
        run_xfer("bp", 32'h100, 4'd3, 16'd2, 1);
        run_xfer("zero", 32'h200, 4'd2, 16'd0, 0);
        chk("zero_no_reads", 64'(adr_q[0].size() + adr_q[1].size()), 64'd0);
        run_xfer("wrap", 32'hFFFF_FFFE, 4'd1, 16'd2, 0);
        run_xfer("en_gate", 32'h100, 4'd3, 16'd2, 2);
        run_xfer("vs0", 32'h40, 4'd0, 16'd5, 0);

        // Abort a 16-word transfer part-way through.
        clear_mon();
        @(posedge clk); #1;
        start = 1'b1; f_array_ptr = 32'h300; vertexSize = 4'd3; num_frags = 16'd4;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        for (int j = 0; j < 2; j++) begin
            chk("midrst_valid", out_valid[j], 1'b0);
            chk("midrst_ready", ready[j], 1'b1);
            chk("midrst_rd_en", rd_en[j], 1'b0);
            chk("midrst_data", out_data[j], 32'd0);
            chk("midrst_stall", stall[j], 32'd0);
        end
        repeat (5) @(posedge clk);
        run_xfer("after_rst", 32'h300, 4'd3, 16'd4, 0);

        for (int r = 0; r < 6; r++) begin
            run_xfer("rand", $urandom, 4'($urandom_range(0, 15)), 16'($urandom_range(0, 4)), 3);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
